// File: rtl/mfp_input_conditioner.sv
// rtl/mfp_input_conditioner.sv - N-channel pushbutton/switch front end
// Synchroniser, tick debounce, edge pulses, long-press with auto-repeat, sticky events.
module mfp_input_conditioner #(
    parameter int              N_CH         = 21,
    parameter int              TICK_DIV     = 50000,
    parameter int              DB_TICKS     = 5,
    parameter int              LONG_TICKS   = 1000,
    parameter int              REPEAT_TICKS = 200,
    parameter logic [N_CH-1:0] RST_VAL      = {N_CH{1'b0}}
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [N_CH-1:0] raw_in,
    input  logic [N_CH-1:0] repeat_en,
    input  logic [N_CH-1:0] evt_clr,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_p,
    output logic [N_CH-1:0] evt,
    output logic            tick
);

    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W     = (DB_TICKS > 1) ? $clog2(DB_TICKS + 1) : 1;
    localparam int HOLD_TOP = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HOLD_W   = $clog2(HOLD_TOP + 1);
    localparam int HOLD_W1  = HOLD_W + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_TICKS - 1);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [HOLD_W1-1:0] LONG_T  = HOLD_W1'(LONG_TICKS);
    localparam logic [HOLD_W1-1:0] REP_T   = HOLD_W1'(REPEAT_TICKS);
    localparam logic [HOLD_W1-1:0] HOLD_ONE = HOLD_W1'(1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = {HOLD_W{1'b1}};

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_REPEAT = 1'b1
    } phase_t;

    logic [DIV_W-1:0] div_cnt;
    logic [N_CH-1:0]  s1;
    logic [N_CH-1:0]  s2;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DB_W-1:0]    cnt;
        logic               db_q;
        logic               rise_q;
        logic               fall_q;
        logic               lp_q;
        logic               evt_q;
        logic [HOLD_W-1:0]  hold;
        logic [HOLD_W-1:0]  hold_nxt;
        logic [HOLD_W1-1:0] hold_inc;
        logic               lp_nxt;
        phase_t             phase;
        phase_t             phase_nxt;

        // Any cycle where the input agrees with db_out restarts the count,
        // so only an uninterrupted run of differing ticks flips the level.
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                db_q   <= RST_VAL[g];
                cnt    <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s2[g] == db_q) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == DB_LAST) begin
                        db_q   <= s2[g];
                        cnt    <= '0;
                        rise_q <= s2[g];
                        fall_q <= ~s2[g];
                    end else begin
                        cnt <= cnt + DB_ONE;
                    end
                end
            end
        end

        assign hold_inc = {1'b0, hold} + HOLD_ONE;

        always_comb begin
            hold_nxt  = hold;
            phase_nxt = phase;
            lp_nxt    = 1'b0;
            if (!db_q) begin
                hold_nxt  = '0;
                phase_nxt = PH_FIRST;
            end else if (tick) begin
                if (phase == PH_FIRST) begin
                    if (hold_inc == LONG_T) begin
                        lp_nxt    = 1'b1;
                        hold_nxt  = '0;
                        phase_nxt = PH_REPEAT;
                    end else begin
                        hold_nxt = hold_inc[HOLD_W-1:0];
                    end
                end else begin
                    // >= lets a late repeat enable fire on the next tick
                    // instead of being stuck behind a saturated count.
                    if (repeat_en[g] && (hold_inc >= REP_T)) begin
                        lp_nxt   = 1'b1;
                        hold_nxt = '0;
                    end else if (hold != HOLD_SAT) begin
                        hold_nxt = hold_inc[HOLD_W-1:0];
                    end
                end
            end
        end

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                hold  <= '0;
                phase <= PH_FIRST;
                lp_q  <= 1'b0;
            end else begin
                hold  <= hold_nxt;
                phase <= phase_nxt;
                lp_q  <= lp_nxt;
            end
        end

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                evt_q <= 1'b0;
            end else begin
                evt_q <= rise_q | lp_q | (evt_q & ~evt_clr[g]);
            end
        end

        assign db_out[g] = db_q;
        assign rise[g]   = rise_q;
        assign fall[g]   = fall_q;
        assign long_p[g] = lp_q;
        assign evt[g]    = evt_q;
    end

endmodule
